// File: rtl/rom_read_arbiter_if.sv
// Bundle between the renderers/ROM (master side) and the shared-ROM read arbiter (slave side).
// The master side drives the request lines and returns ROM data; the arbiter drives grants, ROM port and responses.
interface rom_read_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*ADDR_WIDTH-1:0] addr;
  logic [N_REQ-1:0]            gnt;
  logic                        rom_en;
  logic [ADDR_WIDTH-1:0]       rom_addr;
  logic [DATA_WIDTH-1:0]       rom_data;
  logic [N_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]       rsp_data;

  modport master (
    output req, addr, rom_data,
    input  gnt, rom_en, rom_addr, rsp_valid, rsp_data
  );

  modport slave (
    input  req, addr, rom_data,
    output gnt, rom_en, rom_addr, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sprite/tile ROM port between N_REQ renderers.
// A tag pipeline matched to ROM_LAT routes each returning word back to the requester that issued it.
module rom_read_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int ROM_LAT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  rom_read_arbiter_if.slave  bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [N_REQ-1:0]      gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;

  logic                  rom_en_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;

  logic [ROM_LAT:0]      tag_vld_q;
  logic [IDX_W-1:0]      tag_idx_q [ROM_LAT+1];
  logic [N_REQ-1:0]      rsp_valid;

  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // Arbitration: first requester at or above ptr, wrapping
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    accept   = 1'b0;
    if (!rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!accept && bus.req[wrap_idx(int'(ptr_q), k)]) begin
          accept  = 1'b1;
          gnt_idx = wrap_idx(int'(ptr_q), k);
        end
      end
      if (accept) gnt[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    sel_addr = bus.addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    if (accept) ptr_d = wrap_idx(int'(gnt_idx), 1);
  end

  // Issue stage: pointer, ROM enable and address
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rom_en_q <= accept;
      if (accept) rom_addr_q <= sel_addr;
    end
  end

  // Tag pipeline: valid bits are reset, requester indices simply shift
  always_ff @(posedge clk) begin
    if (rst) tag_vld_q <= '0;
    else     tag_vld_q <= {tag_vld_q[ROM_LAT-1:0], accept};
  end

  always_ff @(posedge clk) begin
    tag_idx_q[0] <= gnt_idx;
    for (int s = 1; s <= ROM_LAT; s++) tag_idx_q[s] <= tag_idx_q[s-1];
  end

  // Response stage
  always_comb begin
    rsp_valid = '0;
    if (tag_vld_q[ROM_LAT] && !rst) rsp_valid[tag_idx_q[ROM_LAT]] = 1'b1;
  end

  assign bus.gnt       = gnt;
  assign bus.rom_en    = rom_en_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = bus.rom_data;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scenario bench for rom_read_arbiter: a behavioural ROM plus a scoreboard of expected responses keyed by due cycle.
module tb_rom_read_arbiter;
  localparam int N   = 4;
  localparam int AW  = 12;
  localparam int DW  = 12;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_read_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_read_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    return (a * 12'd7) + 12'd3;
  endfunction

  // ROM: data for the address sampled LAT edges ago
  logic [AW-1:0] rp [LAT];
  always_ff @(posedge clk) begin
    rp[0] <= bus.rom_addr;
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign bus.rom_data = romf(rp[LAT-1]);

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            m_ptr = 0;
  logic          m_known = 1'b0;
  logic          exp_en = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [N-1:0]  last_gnt;
  logic          last_en;
  logic [AW-1:0] last_addr;
  int            n_rsp = 0;

  function automatic logic [N*AW-1:0] pk(input logic [AW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*AW-1:0] ad, output int gi);
    logic [N-1:0]  eg;
    logic [N-1:0]  er;
    logic [DW-1:0] ed;
    int            j;
    @(negedge clk);
    cyc++;
    if (m_known) begin
      er = '0;
      ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        er[sb[0].idx] = 1'b1;
        ed = sb[0].data;
        void'(sb.pop_front());
      end
      vectors++;
      if (bus.rom_en !== exp_en) begin
        miscompares++;
        $display("FAIL rom_en cyc=%0d: got %b expected %b", cyc, bus.rom_en, exp_en);
      end
      vectors++;
      if (bus.rom_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL rom_addr cyc=%0d: got %h expected %h", cyc, bus.rom_addr, exp_addr);
      end
      vectors++;
      if (bus.rsp_valid !== er) begin
        miscompares++;
        $display("FAIL rsp_valid cyc=%0d: got %b expected %b", cyc, bus.rsp_valid, er);
      end
      if (er != '0) begin
        vectors++;
        if (bus.rsp_data !== ed) begin
          miscompares++;
          $display("FAIL rsp_data cyc=%0d: got %h expected %h", cyc, bus.rsp_data, ed);
        end
      end
      if (bus.rsp_valid != '0) n_rsp++;
      last_en   = bus.rom_en;
      last_addr = bus.rom_addr;
    end
    rst      = r;
    bus.req  = rq;
    bus.addr = ad;
    #1;
    eg = '0;
    gi = -1;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (gi < 0 && rq[j]) gi = j;
      end
      if (gi >= 0) eg[gi] = 1'b1;
    end
    vectors++;
    if (bus.gnt !== eg) begin
      miscompares++;
      $display("FAIL gnt cyc=%0d: got %b expected %b", cyc, bus.gnt, eg);
    end
    last_gnt = bus.gnt;
    if (r) begin
      m_ptr    = 0;
      exp_en   = 1'b0;
      exp_addr = '0;
      sb.delete();
      m_known  = 1'b1;
    end else begin
      exp_en = (gi >= 0);
      if (gi >= 0) begin
        exp_addr = ad[gi*AW +: AW];
        sb.push_back('{cyc + 1 + LAT, gi, romf(ad[gi*AW +: AW])});
        m_ptr = (gi + 1) % N;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N*AW-1:0] ad);
    int g;
    step(r, rq, ad, g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
  endtask

  task automatic expect_gnt(input string nm, input logic [N-1:0] e);
    vectors++;
    if (last_gnt !== e) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", nm, last_gnt, e);
    end
  endtask

  task automatic expect_cnt(input string nm, input int e);
    vectors++;
    if (n_rsp != e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, n_rsp, e);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 4'b1111, pk(12'h001, 12'h002, 12'h003, 12'h004));
    drive(1'b1, 4'b1111, pk(12'h001, 12'h002, 12'h003, 12'h004));
    expect_gnt("reset_gnt", 4'b0000);
    drive(1'b0, 4'b1111, pk(12'h001, 12'h002, 12'h003, 12'h004));
    expect_gnt("first_gnt_after_reset", 4'b0001);
    idle(LAT + 3);
  endtask

  task automatic test_lone_requester();
    n_rsp = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b0100, pk(12'h000, 12'h000, AW'(12'h010 + i), 12'h000));
      expect_gnt("lone_gnt", 4'b0100);
    end
    idle(LAT + 3);
    expect_cnt("lone_rsp_count", 5);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order [6];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    drive(1'b1, '0, '0);
    n_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'b1111, pk(AW'(12'h100 + i), AW'(12'h211 + i), AW'(12'h322 + i), AW'(12'h433 + i)));
      expect_gnt("rr_order", order[i]);
    end
    idle(LAT + 3);
    expect_cnt("rr_rsp_count", 6);
  endtask

  task automatic test_ptr_advance();
    drive(1'b1, '0, '0);
    drive(1'b0, 4'b0100, pk(12'h000, 12'h000, 12'h0AB, 12'h000));
    expect_gnt("single_req2", 4'b0100);
    drive(1'b0, 4'b1111, pk(12'h0C0, 12'h0C1, 12'h0C2, 12'h0C3));
    expect_gnt("ptr_after_req2", 4'b1000);
    drive(1'b0, 4'b1111, pk(12'h0C0, 12'h0C1, 12'h0C2, 12'h0C3));
    expect_gnt("ptr_wrap", 4'b0001);
    idle(LAT + 3);
  endtask

  task automatic test_reset_midflight();
    drive(1'b0, 4'b0010, pk(12'h000, 12'h7E1, 12'h000, 12'h000));
    expect_gnt("mid_req1", 4'b0010);
    drive(1'b0, 4'b1000, pk(12'h000, 12'h000, 12'h000, 12'h7E3));
    expect_gnt("mid_req3", 4'b1000);
    n_rsp = 0;
    drive(1'b1, '0, '0);
    idle(LAT + 2);
    expect_cnt("mid_rsp_after_reset", 0);
  endtask

  task automatic test_idle_hold();
    drive(1'b0, 4'b0100, pk(12'h000, 12'h000, 12'h5A5, 12'h000));
    expect_gnt("idle_setup", 4'b0100);
    n_rsp = 0;
    idle(10 + LAT);
    expect_cnt("idle_rsp_count", 1);
    vectors++;
    if (last_en !== 1'b0 || last_addr !== 12'h5A5) begin
      miscompares++;
      $display("FAIL idle_rom_hold: got en=%b addr=%h expected en=0 addr=5a5", last_en, last_addr);
    end
    drive(1'b0, 4'b1111, pk(12'h001, 12'h002, 12'h003, 12'h004));
    expect_gnt("idle_ptr_kept", 4'b1000);
    idle(LAT + 3);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0]  pend;
    logic [AW-1:0] pa [N];
    int            g;
    pend = '0;
    for (int i = 0; i < N; i++) pa[i] = '0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pa[i]   = AW'($urandom);
        end
      step(1'b0, pend, pk(pa[0], pa[1], pa[2], pa[3]), g);
      if (g >= 0) pend[g] = 1'b0;
    end
    idle(LAT + 3);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_drain: got %0d outstanding expected 0", sb.size());
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.req  = '0;
    bus.addr = '0;
    test_reset();
    test_lone_requester();
    test_round_robin();
    test_ptr_advance();
    test_reset_midflight();
    test_idle_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
